// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port scratch memory.
// Response data is carried at a fixed maximum width; instances zero-extend their words into it.
package mem_pkg;

    localparam int MEM_LAT_MIN    = 1;
    localparam int MEM_LAT_MAX    = 4;
    localparam int MEM_MAX_DATA_W = 512;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [MEM_MAX_DATA_W-1:0] data;
    } mem_rsp_t;

    // Flags an access that is outside the window or not word aligned.
    function automatic logic mem_addr_bad(input logic [31:0] off,
                                          input logic [31:0] addr,
                                          input logic [63:0] range,
                                          input logic [31:0] align_mask);
        return ({32'd0, off} >= range) || ((addr & align_mask) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-depth response delay line; every stage flushes on reset so nothing
// accepted before a reset can emerge afterwards.
module mem_rsp_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  mem_rsp_t rsp_in,
    output mem_rsp_t rsp_out
);

    mem_rsp_t stage_r [LATENCY];

    // Shift the response one stage per cycle; stage 0 captures the new entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= rsp_in;
            for (int i = 1; i < LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign rsp_out = stage_r[LATENCY-1];

endmodule

// File: rtl/mem_2p.sv
// Two-port (instruction read / data read-write) word memory that zero-fills
// itself after reset and answers every accepted request after LATENCY cycles.
module mem_2p
    import mem_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [31:0]         i_addr,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rsp_err,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_wen,
    input  logic [31:0]         d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rsp_err
);

    localparam int          BYTES      = DATA_W / 8;
    localparam int          OFF_W      = $clog2(BYTES);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [63:0] RANGE      = 64'(DEPTH) * 64'(BYTES);
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    mem_state_e        state_r;
    mem_state_e        state_next_s;
    logic [AW-1:0]     clr_idx_r;
    logic [AW-1:0]     clr_idx_next_s;
    logic              clr_we_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [31:0]       i_off_s;
    logic [31:0]       d_off_s;
    logic [AW-1:0]     i_idx_s;
    logic [AW-1:0]     d_idx_s;
    logic              i_bad_s;
    logic              d_bad_s;
    logic              i_acc_s;
    logic              d_acc_s;
    logic              d_we_s;
    mem_rsp_t          i_rsp_in_s;
    mem_rsp_t          d_rsp_in_s;
    mem_rsp_t          i_rsp_s;
    mem_rsp_t          d_rsp_s;

    // State and zero-fill index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= '0;
        end else begin
            state_r   <= state_next_s;
            clr_idx_r <= clr_idx_next_s;
        end
    end

    // Zero-fill sequencing: one word per cycle, READY once the last word is written.
    always_comb begin
        state_next_s   = state_r;
        clr_idx_next_s = clr_idx_r;
        clr_we_s       = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_we_s = 1'b1;
                if (clr_idx_r == LAST_IDX) begin
                    state_next_s   = ST_READY;
                    clr_idx_next_s = '0;
                end else begin
                    clr_idx_next_s = clr_idx_r + AW'(1);
                end
            end
            ST_READY: begin
                state_next_s = ST_READY;
            end
            default: begin
                state_next_s   = ST_CLEAR;
                clr_idx_next_s = '0;
            end
        endcase
    end

    assign i_req_ready = (state_r == ST_READY);
    assign d_req_ready = (state_r == ST_READY);

    // Offsets wrap modulo 2^32, so addresses below the base land far out of range.
    assign i_off_s = i_addr - BASE_ADDR;
    assign d_off_s = d_addr - BASE_ADDR;
    assign i_idx_s = i_off_s[OFF_W +: AW];
    assign d_idx_s = d_off_s[OFF_W +: AW];
    assign i_bad_s = mem_addr_bad(i_off_s, i_addr, RANGE, ALIGN_MASK);
    assign d_bad_s = mem_addr_bad(d_off_s, d_addr, RANGE, ALIGN_MASK);

    assign i_acc_s = i_req_valid & i_req_ready;
    assign d_acc_s = d_req_valid & d_req_ready;
    assign d_we_s  = d_acc_s & d_wen & ~d_bad_s;

    // Storage write port shared by zero-fill and byte-masked data writes.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_idx_r] <= '0;
        end else if (d_we_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (d_wstrb[b]) begin
                    mem_r[d_idx_s][b*8 +: 8] <= d_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Response entries; the array is sampled before this edge's write lands,
    // which gives same-cycle I reads the old word.
    always_comb begin
        i_rsp_in_s = '0;
        d_rsp_in_s = '0;
        if (i_acc_s) begin
            i_rsp_in_s.valid = 1'b1;
            i_rsp_in_s.err   = i_bad_s;
            i_rsp_in_s.data  = i_bad_s ? '0 : MEM_MAX_DATA_W'(mem_r[i_idx_s]);
        end else begin
            i_rsp_in_s = '0;
        end
        if (d_acc_s) begin
            d_rsp_in_s.valid = 1'b1;
            d_rsp_in_s.err   = d_bad_s;
            d_rsp_in_s.data  = (d_bad_s || d_wen) ? '0 : MEM_MAX_DATA_W'(mem_r[d_idx_s]);
        end else begin
            d_rsp_in_s = '0;
        end
    end

    mem_rsp_pipe #(.LATENCY(LATENCY)) u_i_pipe (
        .clk     (clk),
        .reset   (reset),
        .rsp_in  (i_rsp_in_s),
        .rsp_out (i_rsp_s)
    );

    mem_rsp_pipe #(.LATENCY(LATENCY)) u_d_pipe (
        .clk     (clk),
        .reset   (reset),
        .rsp_in  (d_rsp_in_s),
        .rsp_out (d_rsp_s)
    );

    assign i_rsp_valid = i_rsp_s.valid;
    assign i_rsp_err   = i_rsp_s.err;
    assign i_rdata     = i_rsp_s.data[DATA_W-1:0];
    assign d_rsp_valid = d_rsp_s.valid;
    assign d_rsp_err   = d_rsp_s.err;
    assign d_rdata     = d_rsp_s.data[DATA_W-1:0];

    // Upper response bits are always zero for narrower words.
    if (DATA_W < MEM_MAX_DATA_W) begin : g_sink
        logic unused_rsp_bits_s;
        assign unused_rsp_bits_s = ^{i_rsp_s.data[MEM_MAX_DATA_W-1:DATA_W],
                                     d_rsp_s.data[MEM_MAX_DATA_W-1:DATA_W]};
    end

endmodule

// File: tb/tb_mem_2p.sv
// Randomized and directed bench for mem_2p with a queue-based scoreboard
// fed by a word-array reference model.
module tb_mem_2p;

    localparam int          DATA_W  = 32;
    localparam int          DEPTH   = 64;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req_valid = 1'b0, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_addr = 32'd0, i_rdata;
    logic        d_req_valid = 1'b0, d_req_ready, d_wen = 1'b0, d_rsp_valid, d_rsp_err;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0, d_rdata;
    logic [3:0]  d_wstrb = 4'd0;

    mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_wen(d_wen),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_rsp_err(d_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          i_rx = 0;
    int          d_rx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference read: window and alignment rules computed on byte offsets.
    function automatic exp_t ref_read(input logic [31:0] a);
        exp_t        e;
        logic [31:0] off;
        off   = a - BASE;
        e.err = (off >= 32'(DEPTH * 4)) || ((a % 32'd4) != 32'd0);
        e.data = e.err ? 32'd0 : model_mem[off / 32'd4];
        e.cyc = cyc;
        return e;
    endfunction

    // Model: record accepted requests and apply writes after I reads are taken.
    initial forever begin
        exp_t ie;
        exp_t de;
        int   wi;
        @(posedge clk);
        if (!reset) begin
            if (i_req_valid && i_req_ready) begin
                ie = ref_read(i_addr);
                iq.push_back(ie);
            end
            if (d_req_valid && d_req_ready) begin
                de = ref_read(d_addr);
                if (d_wen) begin
                    de.data = 32'd0;
                    if (!de.err) begin
                        wi = int'((d_addr - BASE) / 32'd4);
                        for (int b = 0; b < 4; b++) begin
                            if (d_wstrb[b]) model_mem[wi][8*b +: 8] = d_wdata[8*b +: 8];
                        end
                    end
                end
                dq.push_back(de);
            end
        end
        cyc++;
    end

    // Monitor: pop and compare each response; idle outputs must be zero.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (i_rsp_valid) begin
            i_rx++;
            if (iq.size() == 0) begin
                checks++; failures++;
                $display("FAIL i_unexpected actual=%0h expected=none", i_rdata);
            end else begin
                e = iq.pop_front();
                check("i_rsp", 64'({i_rsp_err, i_rdata}), 64'({e.err, e.data}));
                check("i_lat", 64'(cyc - e.cyc), 64'(LATENCY));
            end
        end else begin
            check("i_idle_zero", 64'({i_rsp_err, i_rdata}), 64'd0);
        end
        if (d_rsp_valid) begin
            d_rx++;
            if (dq.size() == 0) begin
                checks++; failures++;
                $display("FAIL d_unexpected actual=%0h expected=none", d_rdata);
            end else begin
                e = dq.pop_front();
                check("d_rsp", 64'({d_rsp_err, d_rdata}), 64'({e.err, e.data}));
                check("d_lat", 64'(cyc - e.cyc), 64'(LATENCY));
            end
        end else begin
            check("d_idle_zero", 64'({d_rsp_err, d_rdata}), 64'd0);
        end
    end

    task automatic drive(input logic iv, input logic [31:0] ia,
                         input logic dv, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [3:0] ds);
        i_req_valid = iv; i_addr = ia;
        d_req_valid = dv; d_wen = dw; d_addr = da; d_wdata = dd; d_wstrb = ds;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Reset in the high phase (requests may be in flight), then time the zero-fill.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        iq.delete();
        dq.delete();
        @(negedge clk);
        @(negedge clk);
        check("ready_in_reset", 64'({i_req_ready, d_req_ready}), 64'd0);
        check("rsp_in_reset", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
        for (int w = 0; w < DEPTH; w++) model_mem[w] = 32'd0;
        reset = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 || k >= DEPTH - 1)
                check("ready_rise", 64'({i_req_ready, d_req_ready}), (k == DEPTH) ? 64'd3 : 64'd0);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)      return BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (r == 1) return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7) * 4);
        else if (r == 2) return BASE - 32'($urandom_range(1, 4) * 4);
        else             return BASE + 32'($urandom_range(0, 15) * 4);
    endfunction

    initial begin
        int i0;
        int d0;
        do_reset();

        // Freshly cleared word reads as zero on both ports.
        drive(1'b1, BASE + 32'd4, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 4'd0);
        idle(LATENCY + 1);

        // Full write then single-byte merge, read back on both ports.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010);
        drive(1'b1, 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'd0);
        drive(1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(LATENCY + 1);

        // Same-cycle I read and D write: old data, then new data.
        drive(1'b1, 32'h8000_0020, 1'b1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF);
        drive(1'b1, 32'h8000_0020, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(LATENCY + 1);

        // Misaligned / out-of-window accesses error out and never write.
        drive(1'b1, 32'h8000_0002, 1'b1, 1'b0, 32'h8000_0002, 32'd0, 4'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b1, BASE + 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF);
        drive(1'b0, 32'd0, 1'b1, 1'b1, BASE - 32'd4, 32'hFFFF_FFFF, 4'hF);
        drive(1'b1, BASE, 1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'd0);
        drive(1'b1, BASE + 32'(DEPTH * 4 - 4), 1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'd0);
        idle(LATENCY + 1);

        // Random traffic over a small window to force address reuse.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_addr(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_addr(),
                  $urandom, 4'($urandom_range(0, 15)));
        end
        idle(LATENCY + 1);

        // Back-to-back reads for 16 cycles on both ports.
        i0 = i_rx;
        d0 = d_rx;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, BASE + 32'(k * 4), 1'b1, 1'b0, BASE + 32'((15 - k) * 4), 32'd0, 4'd0);
        end
        idle(LATENCY + 1);
        check("i_count16", 64'(i_rx - i0), 64'd16);
        check("d_count16", 64'(d_rx - d0), 64'd16);

        // Reset while a read stream is running; requests stay asserted through CLEAR.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, BASE + 32'(k * 4), 1'b1, 1'b0, BASE + 32'(k * 4 + 8), 32'd0, 4'd0);
        end
        do_reset();
        drive(1'b1, 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'd0);
        idle(LATENCY + 2);

        check("i_queue_empty", 64'(iq.size()), 64'd0);
        check("d_queue_empty", 64'(dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_2p.md
MEM_2P -- requirements
Module: mem_2p

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 4096: number of words; SHALL be a power of two, at least 2.
REQ-003 Parameter LATENCY, default 1: cycles from request acceptance to response; legal range 1..4.
REQ-004 Parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-005 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1: reset, asynchronous, active-high.
REQ-007 Ports i_req_valid (in, 1) and i_req_ready (out, 1): instruction-port read handshake.
REQ-008 Port i_addr, input, 32: instruction-port byte address.
REQ-009 Ports i_rsp_valid (out, 1), i_rdata (out, DATA_W) and i_rsp_err (out, 1): instruction-port response.
REQ-010 Ports d_req_valid (in, 1), d_req_ready (out, 1) and d_wen (in, 1): data-port handshake; d_wen=1 selects write.
REQ-011 Ports d_addr (in, 32), d_wdata (in, DATA_W) and d_wstrb (in, DATA_W/8): data-port address, write data and byte strobes.
REQ-012 Ports d_rsp_valid (out, 1), d_rdata (out, DATA_W) and d_rsp_err (out, 1): data-port response, issued for reads and writes.

Function
REQ-013 The block SHALL have two states, CLEAR and READY.
REQ-014 CLEAR SHALL write zero to one word per cycle, index 0 to DEPTH-1, then enter READY on the cycle after the last word is written.
REQ-015 i_req_ready and d_req_ready SHALL be 0 in CLEAR and 1 in READY.
REQ-016 A request SHALL be accepted on a rising edge where valid and ready are both 1; one request per port per cycle.
REQ-017 An accepted request SHALL produce exactly one response with rsp_valid=1, LATENCY cycles after acceptance; responses SHALL NOT stall.
REQ-018 Responses SHALL return in request order; the two ports are independent.
REQ-019 Word index SHALL be (addr - BASE_ADDR) >> log2(DATA_W/8), computed modulo 2^32.
REQ-020 An address is out of range when (addr - BASE_ADDR) >= DEPTH*DATA_W/8; the response SHALL then have err=1 and rdata=0, and a write SHALL be suppressed.
REQ-021 An address is misaligned when its low log2(DATA_W/8) bits are nonzero; the response SHALL then have err=1 and rdata=0, and a write SHALL be suppressed.
REQ-022 A write SHALL update only the bytes whose d_wstrb bit is 1; d_wstrb=0 is a legal no-op that still produces a response.
REQ-023 A write response SHALL have d_rdata=0.
REQ-024 A read SHALL see all writes accepted in earlier cycles.
REQ-025 When an I read and a D write to the same word are accepted in the same cycle, the I read SHALL return the pre-write data.
REQ-026 When rsp_valid=0, rdata and err SHALL be 0.

Reset
REQ-027 While reset is asserted: all rsp_valid, rdata and err outputs SHALL be 0, both ready outputs SHALL be 0, and the response pipeline SHALL be flushed.
REQ-028 On reset deassertion the block SHALL start in CLEAR at index 0, including when reset arrives mid-CLEAR or with requests in flight; in-flight requests SHALL get no response.

Structure
REQ-029 A shared package mem_pkg SHALL hold the state enum, the response struct {valid, err, data}, and the LATENCY bounds.
REQ-030 One sub-module, mem_rsp_pipe (LATENCY-deep response shift register, one instance per port), SHALL be used.
REQ-031 Storage SHALL be a synthesizable array with no DPI calls.

Verification
REQ-032 Reset, then wait: ready rises exactly DEPTH cycles after reset deassertion; a read of BASE_ADDR+4 returns 0 with err=0.
REQ-033 LATENCY=2: D write 0xDEADBEEF to 0x8000_0010 with wstrb 4'b1111, then wstrb 4'b0010 with data 0x0000_5500; a read returns 0xDEAD55EF exactly 2 cycles after acceptance.
REQ-034 Same-cycle I read and D write 0x1234_5678 to 0x8000_0020 (word previously 0): I returns 0; an I read issued the next cycle returns 0x1234_5678.
REQ-035 Read of 0x8000_0002 and write to BASE_ADDR+DEPTH*4: both responses have err=1 and rdata=0; a follow-up read shows memory unchanged.
REQ-036 Back-to-back reads on both ports for 16 cycles: 16 in-order responses per port; then reset asserted mid-stream: no further rsp_valid until a new CLEAR completes.
